nco_rate_detector: RTL and testbench
====================================

# nco_rate_detector

Receive-side companion to the `nco` clock divider. It samples a divided waveform such as `nco.op` and measures its period in `clk` cycles. It decodes which of the four divide settings (the `sigSel` encoding) produced the waveform and reports lock once the rate is stable. It sits downstream of an `nco` instance or on a board pin, and gives self-checking logic and status registers a recovered `sigSel` value.

## Interface
Parameters:
- `DIV0`, default 2: expected period in `clk` cycles for selector 0.
- `DIV1`, default 4: expected period for selector 1.
- `DIV2`, default 8: expected period for selector 2.
- `DIV3`, default 16: expected period for selector 3.
- `TOL`, default 1: allowed absolute period error, in cycles.
- `LOCK_CNT`, default 3: number of consecutive same-selector matches needed to lock.
- `TIMEOUT`, default 1024: number of cycles with no rising edge before `no_signal` is raised.
- `CNT_W`, default 16: counter and period width. Must satisfy `2^CNT_W > TIMEOUT`.

Ports:
- `clk`: input, 1. The single clock.
- `rst`: input, 1. Synchronous, active-high reset.
- `sig_in`: input, 1. Divided waveform. Treated as asynchronous.
- `period`: output, `CNT_W`. Last measured rising-to-rising period, in cycles.
- `period_valid`: output, 1. One-cycle pulse when `period` is updated.
- `det_sel`: output, 2. Decoded selector. Updated only on lock.
- `locked`: output, 1. The rate has been stable for `LOCK_CNT` measurements.
- `no_signal`: output, 1. No rising edge has been seen for `TIMEOUT` cycles.

## Operation
**Synchronizer and edge detect**
- Three-flop chain: `s1 <= sig_in`, `s2 <= s1`, `s3 <= s2`.
- Rising edge `rise = s2 & ~s3`, combinational.

**Period counter `cnt`**
- Loads 1 on `rise`.
- Otherwise increments by 1, saturating at `TIMEOUT`.
- Consequence: rising edges P cycles apart give `cnt == P` on the second `rise`.

**FSM**
- `IDLE`, entered on reset or timeout:
  - On `rise`, go to `ARM`.
  - No measurement is taken, and `no_signal` is cleared.
- `ARM`:
  - On `rise`, capture `period <= cnt` and pulse `period_valid`.
  - Evaluate the match and go to `TRACK`.
- `TRACK`:
  - Every `rise` captures and evaluates.
  - Go to `LOCKED` when the match count reaches `LOCK_CNT`.
- `LOCKED`:
  - Every `rise` captures and evaluates.
  - A mismatch or a different selector goes to `TRACK` with `locked` cleared.

**Match**
- Selector k matches if `|period_meas - DIVk| <= TOL`.
- The difference is computed unsigned at `CNT_W+1` bits.
- If several selectors match, the lowest k wins. No match sets the match flag to 0.

**Match counter**
- Same k as the previous measurement: increment, saturating at `LOCK_CNT`.
- Different k: reset to 1.
- No match: reset to 0.
- On entry to `LOCKED`, `det_sel <= k` and `locked <= 1`.
- `det_sel` holds its value after lock loss.

**Timeout**
- When `cnt` reaches `TIMEOUT` in any state other than `IDLE`: `no_signal <= 1`, `locked <= 0`, match count cleared, go to `IDLE`.
- `period` and `det_sel` hold their values.

**Other rules**
- The duty cycle of `sig_in` is irrelevant; only rising edges are used.
- `rise` and timeout in the same cycle: `rise` wins, and no timeout is taken.

## Timing
**Reset values** (synchronous `rst`)
- `period = 0`, `period_valid = 0`, `det_sel = 0`, `locked = 0`, `no_signal = 0`.
- State `IDLE`, `cnt = 0`, synchronizer flops cleared.
- `rst` asserted mid-measurement discards the measurement in progress. The next lock needs two rising edges plus `LOCK_CNT` matches.

**Latency**
- `sig_in` first sampled high at clock edge n: `rise` is active during the cycle after edge n+1.
- `period` and `period_valid` are visible from edge n+2 for one cycle.
- `locked` rises in the same cycle as the `period_valid` of the `LOCK_CNT`-th consecutive matching measurement.
- `no_signal` rises `TIMEOUT` cycles after the last `cnt` load.

**Throughput**
- Minimum measurable period is 2 cycles.
- `period_valid` never pulses on consecutive cycles.

## Test plan
1. **Reset:** hold `rst` high for 3 cycles with `sig_in` toggling -> all outputs 0. The first `period_valid` comes only on the second post-reset rising edge.
2. **Square wave, period 16 (10 cycles)** -> `period_valid` every 16 cycles with `period = 16`. `locked` rises with the third pulse, and `det_sel = 3`.
3. **Tolerance:** periods 17, 15, 17 -> `locked`, `det_sel = 3`. A steady period of 14 -> `period = 14` with `locked` staying 0. A steady period of 3 -> `det_sel = 0` after lock, because the lowest k wins and 3 matches both `DIV0 = 2` and `DIV1 = 4`.
4. **Rate change while locked (16 -> 4):**
   - The first measurement after the change reports `period = 4`, or an intermediate value depending on the transition; either way `locked` drops to 0.
   - After 3 period-4 measurements, `locked = 1` with `det_sel = 1`.
5. **Loss of signal:** hold `sig_in` low after lock -> exactly 1024 cycles after the last `rise`, `no_signal = 1` and `locked = 0`. Restarting a period-8 wave clears `no_signal` at the first rise. `det_sel = 2` after 3 further matches.
6. **`rst` mid-measurement:** with period 8 and 2 matches accumulated, pulse `rst` -> outputs return to reset values. Relock at the fourth post-reset rising edge.

Source files
------------

// File: rtl/nco_rate_detector.sv
// nco_rate_detector: measures the rising-edge period of an asynchronous divided
// waveform in clk cycles, decodes which of four divide ratios produced it and
// reports lock once the same ratio has been seen LOCK_CNT times in a row.
module nco_rate_detector #(
  parameter int DIV0     = 2,
  parameter int DIV1     = 4,
  parameter int DIV2     = 8,
  parameter int DIV3     = 16,
  parameter int TOL      = 1,
  parameter int LOCK_CNT = 3,
  parameter int TIMEOUT  = 1024,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [1:0]       det_sel,
  output logic             locked,
  output logic             no_signal
);

  localparam int               MC_W   = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] TMO_V  = CNT_W'(TIMEOUT);
  localparam logic [MC_W-1:0]  LOCK_V = MC_W'(LOCK_CNT);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_TRACK, S_LOCKED} state_e;

  // |meas - div| <= TOL, evaluated unsigned one bit wider than the counter
  // so the subtraction can never wrap.
  function automatic logic within_tol(input logic [CNT_W-1:0] meas, input int div);
    logic [CNT_W:0] a;
    logic [CNT_W:0] b;
    logic [CNT_W:0] diff;
    a    = {1'b0, meas};
    b    = (CNT_W+1)'(div);
    diff = (a >= b) ? (a - b) : (b - a);
    return diff <= (CNT_W+1)'(TOL);
  endfunction

  // Period counter increment, parked at TIMEOUT while no edge arrives.
  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
    return (v >= TMO_V) ? v : v + CNT_W'(1);
  endfunction

  // Consecutive-match counter increment, parked at LOCK_CNT.
  function automatic logic [MC_W-1:0] mcnt_sat_inc(input logic [MC_W-1:0] v);
    return (v >= LOCK_V) ? v : v + MC_W'(1);
  endfunction

  logic             s1_q, s2_q, s3_q;
  logic             rise;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             pv_q, pv_d;
  logic [1:0]       det_q, det_d;
  logic             locked_q, locked_d;
  logic             nosig_q, nosig_d;
  logic [MC_W-1:0]  mcnt_q, mcnt_d, mcnt_meas;
  logic [1:0]       prevk_q, prevk_d;
  logic             match_ok;
  logic [1:0]       match_k;

  // Two flops resolve metastability on sig_in, the third holds the previous
  // level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  // Counter restarts at 1 on every edge so it equals the period at the next edge.
  always_comb begin
    cnt_d = rise ? CNT_W'(1) : cnt_sat_inc(cnt_q);
  end

  // Decode the running count against the four ratios; lowest index wins ties.
  always_comb begin
    match_ok = 1'b1;
    match_k  = 2'd0;
    if (within_tol(cnt_q, DIV0))      match_k = 2'd0;
    else if (within_tol(cnt_q, DIV1)) match_k = 2'd1;
    else if (within_tol(cnt_q, DIV2)) match_k = 2'd2;
    else if (within_tol(cnt_q, DIV3)) match_k = 2'd3;
    else                              match_ok = 1'b0;
  end

  // Match count this measurement would produce: extend a run of the same
  // selector, start a new run on a different one, clear on no match.
  always_comb begin
    if (!match_ok)                mcnt_meas = '0;
    else if (match_k == prevk_q)  mcnt_meas = mcnt_sat_inc(mcnt_q);
    else                          mcnt_meas = MC_W'(1);
  end

  // Next-state and output logic of the measurement FSM.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    pv_d     = 1'b0;
    det_d    = det_q;
    locked_d = locked_q;
    nosig_d  = nosig_q;
    mcnt_d   = mcnt_q;
    prevk_d  = prevk_q;
    unique case (state_q)
      S_IDLE: begin
        // First edge only provides the reference point for the next period.
        if (rise) begin
          state_d = S_ARM;
          nosig_d = 1'b0;
        end
      end
      S_ARM, S_TRACK, S_LOCKED: begin
        if (rise) begin
          period_d = cnt_q;
          pv_d     = 1'b1;
          mcnt_d   = mcnt_meas;
          prevk_d  = match_k;
          if (state_q == S_LOCKED) begin
            if (!match_ok || (match_k != det_q)) begin
              state_d  = S_TRACK;
              locked_d = 1'b0;
            end
          end else if ((state_q == S_TRACK) && (mcnt_meas == LOCK_V)) begin
            state_d  = S_LOCKED;
            locked_d = 1'b1;
            det_d    = match_k;
          end else begin
            state_d = S_TRACK;
          end
        end else if (cnt_q == TMO_V) begin
          // Edge starvation: drop lock and wait for a fresh reference edge.
          state_d  = S_IDLE;
          nosig_d  = 1'b1;
          locked_d = 1'b0;
          mcnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and status registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      pv_q     <= 1'b0;
      det_q    <= 2'd0;
      locked_q <= 1'b0;
      nosig_q  <= 1'b0;
      mcnt_q   <= '0;
      prevk_q  <= 2'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      pv_q     <= pv_d;
      det_q    <= det_d;
      locked_q <= locked_d;
      nosig_q  <= nosig_d;
      mcnt_q   <= mcnt_d;
      prevk_q  <= prevk_d;
    end
  end

  assign period       = period_q;
  assign period_valid = pv_q;
  assign det_sel      = det_q;
  assign locked       = locked_q;
  assign no_signal    = nosig_q;

endmodule

// File: tb/tb_nco_rate_detector.sv
// Testbench for nco_rate_detector: directed scenarios plus randomized
// waveforms, every cycle compared against an event-level reference model.
module tb_nco_rate_detector;

  localparam int CNT_W = 16;
  localparam int TOUT  = 1024;
  localparam int LC    = 3;
  localparam int TOL   = 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             sig_in;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic [1:0]       det_sel;
  logic             locked;
  logic             no_signal;

  always #5 clk = ~clk;

  nco_rate_detector #(
    .DIV0(2), .DIV1(4), .DIV2(8), .DIV3(16),
    .TOL(TOL), .LOCK_CNT(LC), .TIMEOUT(TOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sig_in(sig_in),
    .period(period),
    .period_valid(period_valid),
    .det_sel(det_sel),
    .locked(locked),
    .no_signal(no_signal)
  );

  int nchk  = 0;
  int npass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
  endtask

  // ---------------- reference model ----------------
  function automatic int div_of(input int k);
    case (k)
      0: return 2;
      1: return 4;
      2: return 8;
      default: return 16;
    endcase
  endfunction

  // Lowest selector whose ratio lies within TOL of p, or -1.
  function automatic int classify(input int p);
    int d;
    for (int k = 0; k < 4; k++) begin
      d = p - div_of(k);
      if (d < 0) d = -d;
      if (d <= TOL) return k;
    end
    return -1;
  endfunction

  bit chk_en     = 1'b0;
  int cyc        = 0;
  bit w1         = 1'b0;   // reset-masked sample of sig_in at previous edge
  bit w2         = 1'b0;   // and the one before
  bit m_rise_nxt = 1'b0;
  bit m_active   = 1'b0;   // a reference edge has been seen since idle
  bit m_prevok   = 1'b0;
  bit m_locked   = 1'b0;
  bit m_nosig    = 1'b0;
  bit m_pv       = 1'b0;
  int m_run      = 0;
  int m_prevk    = 0;
  int m_det      = 0;
  int m_period   = 0;
  int m_last     = 0;      // edge index at which the last period started

  always @(posedge clk) begin
    bit rs;
    bit sv;
    bit rise;
    bit w_now;
    int p;
    int k;
    rs    = rst;
    sv    = sig_in;
    rise  = m_rise_nxt;
    w_now = rs ? 1'b0 : sv;
    if (rs) begin
      chk_en   = 1'b1;
      m_active = 1'b0;
      m_prevok = 1'b0;
      m_locked = 1'b0;
      m_nosig  = 1'b0;
      m_pv     = 1'b0;
      m_run    = 0;
      m_det    = 0;
      m_period = 0;
      m_last   = cyc + 1;
    end else begin
      m_pv = 1'b0;
      if (rise) begin
        p = cyc - m_last;
        if (p > TOUT) p = TOUT;
        m_last = cyc;
        if (!m_active) begin
          m_active = 1'b1;
          m_nosig  = 1'b0;
        end else begin
          m_period = p;
          m_pv     = 1'b1;
          k        = classify(p);
          if (k < 0) begin
            m_run    = 0;
            m_prevok = 1'b0;
          end else begin
            if (m_prevok && (k == m_prevk)) m_run = (m_run + 1 > LC) ? LC : m_run + 1;
            else                            m_run = 1;
            m_prevok = 1'b1;
            m_prevk  = k;
          end
          if ((m_run == LC) && !m_locked) m_det = k;
          m_locked = (m_run == LC);
        end
      end else if (m_active && (cyc - m_last >= TOUT)) begin
        m_active = 1'b0;
        m_nosig  = 1'b1;
        m_locked = 1'b0;
        m_run    = 0;
        m_prevok = 1'b0;
      end
    end
    // A rising edge is seen two edges after the input is first sampled high.
    m_rise_nxt = !rs && w1 && !w2;
    w2  = w1;
    w1  = w_now;
    cyc++;
    #1;
    if (chk_en) begin
      check("period", 32'(period), 32'(m_period));
      check("period_valid", 32'(period_valid), 32'(m_pv));
      check("det_sel", 32'(det_sel), 32'(m_det));
      check("locked", 32'(locked), 32'(m_locked));
      check("no_signal", 32'(no_signal), 32'(m_nosig));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic v);
    @(negedge clk);
    sig_in = v;
  endtask

  task automatic one_period(input int p);
    int h;
    h = $urandom_range(p - 1, 1);
    for (int i = 0; i < p; i++) tick(i < h);
  endtask

  task automatic wave(input int p, input int n);
    repeat (n) one_period(p);
  endtask

  task automatic hold_low(input int n);
    repeat (n) tick(1'b0);
  endtask

  task automatic pulse_rst(input int n);
    @(negedge clk);
    rst = 1'b1;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst    = 1'b1;
    sig_in = 1'b0;
    // reset held for three edges while the input toggles
    tick(1'b1);
    tick(1'b0);
    tick(1'b1);
    rst = 1'b0;
    check("rst_period", 32'(period), 32'd0);
    check("rst_pv", 32'(period_valid), 32'd0);
    check("rst_det", 32'(det_sel), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_nosig", 32'(no_signal), 32'd0);
    tick(1'b1);
    hold_low(3);

    // steady period 16
    wave(16, 10);
    check("p16_period", 32'(period), 32'd16);
    check("p16_locked", 32'(locked), 32'd1);
    check("p16_det", 32'(det_sel), 32'd3);

    // timeout, then jittered periods around 16
    hold_low(TOUT + 20);
    check("tmo_nosig", 32'(no_signal), 32'd1);
    check("tmo_locked", 32'(locked), 32'd0);
    one_period(17);
    one_period(15);
    one_period(17);
    one_period(17);
    check("jit_locked", 32'(locked), 32'd1);
    check("jit_det", 32'(det_sel), 32'd3);
    check("jit_nosig", 32'(no_signal), 32'd0);

    // period 14 is outside tolerance of every ratio
    wave(14, 8);
    check("p14_period", 32'(period), 32'd14);
    check("p14_locked", 32'(locked), 32'd0);

    // period 3 matches ratios 2 and 4; the lower selector is reported
    wave(3, 8);
    check("p3_locked", 32'(locked), 32'd1);
    check("p3_det", 32'(det_sel), 32'd0);

    // rate change 16 -> 4 while locked
    wave(16, 6);
    check("chg16_locked", 32'(locked), 32'd1);
    check("chg16_det", 32'(det_sel), 32'd3);
    wave(4, 2);
    check("chg4_drop", 32'(locked), 32'd0);
    wave(4, 4);
    check("chg4_locked", 32'(locked), 32'd1);
    check("chg4_det", 32'(det_sel), 32'd1);

    // loss of signal after lock, then restart at period 8
    hold_low(TOUT + 10);
    check("los_nosig", 32'(no_signal), 32'd1);
    check("los_locked", 32'(locked), 32'd0);
    check("los_det_hold", 32'(det_sel), 32'd1);
    wave(8, 6);
    check("p8_nosig", 32'(no_signal), 32'd0);
    check("p8_locked", 32'(locked), 32'd1);
    check("p8_det", 32'(det_sel), 32'd2);

    // reset in the middle of a measurement with two matches accumulated
    pulse_rst(1);
    wave(8, 3);
    hold_low(3);
    pulse_rst(1);
    check("mid_rst_period", 32'(period), 32'd0);
    check("mid_rst_det", 32'(det_sel), 32'd0);
    check("mid_rst_locked", 32'(locked), 32'd0);
    wave(8, 3);
    check("relock_early", 32'(locked), 32'd0);
    one_period(8);
    check("relock_locked", 32'(locked), 32'd1);
    check("relock_det", 32'(det_sel), 32'd2);

    // randomized rates, duty cycles, resets and signal gaps
    for (int s = 0; s < 25; s++) begin
      int p;
      int n;
      int r;
      p = $urandom_range(20, 2);
      n = $urandom_range(6, 1);
      r = $urandom_range(15, 0);
      if (r == 0)      pulse_rst($urandom_range(3, 1));
      else if (r == 1) hold_low($urandom_range(TOUT + 20, TOUT - 20));
      wave(p, n);
    end

    hold_low(5);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
